// File: rtl/multicycle_control.sv
// Sequencing controller for the multicycle RV32I core.
// A Moore FSM steps each instruction through fetch, decode, execute, memory and
// writeback. In each step it drives the datapath mux selects, the write enables
// and the 2-bit Aluop for the ALU decoder.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   op                  opcode Instr[6:0] from the instruction register
//   Zero                ALU zero flag (qualifies beq)
//   mem_ready           memory finished the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   RegWrite, Aluop     datapath controls
//   Illegal             one-cycle pulse in DECODE for an unsupported opcode
//   State               current state, for debug
module multicycle_control #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic [1:0]         Aluop,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpBeq  = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10
  } state_e;

  state_e state_q, state_d;

  logic pc_update, branch;
  logic mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    Aluop         = 2'b00;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;

    case (state_q)
      StFetch: begin
        // PC + 4 goes straight from the ALU into the PC.
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // OldPC + imm: branch target precomputed into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpI:        state_d = StExecI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
          default: begin
            state_d     = StFetch;
            illegal_raw = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        // Strobe held through every stall cycle until memory accepts.
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        Aluop   = 2'b10;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        Aluop   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write_raw = 1'b1;
        state_d       = StFetch;
      end
      StJal: begin
        // ALU forms OldPC + 4 for rd while ALUOut (target) loads the PC.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        Aluop   = 2'b01;
        branch  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Write enables are suppressed during reset so an abandoned instruction
  // cannot commit anything in the reset cycle.
  assign PCWrite  = rst_n & ((branch & Zero) | pc_update);
  assign MemWrite = rst_n & mem_write_raw;
  assign IRWrite  = rst_n & ir_write_raw;
  assign RegWrite = rst_n & reg_write_raw;
  assign Illegal  = rst_n & illegal_raw;
  assign State    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  localparam int unsigned STATE_W = 4;

  logic               clk = 1'b0;
  logic               rst_n, Zero, mem_ready;
  logic [6:0]         op;
  logic               PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]         ResultSrc, ALUSrcA, ALUSrcB, Aluop;
  logic [STATE_W-1:0] State;

  multicycle_control #(.STATE_W(STATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .Aluop(Aluop), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // we = {PCWrite, MemWrite, IRWrite, RegWrite, Illegal}
  localparam logic [4:0] W0 = 5'b00000, WF = 5'b10100, WP = 5'b10000;
  localparam logic [4:0] WM = 5'b01000, WR = 5'b00010, WI = 5'b00001;

  typedef struct {
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mr;
    logic       chk_st;
    logic [3:0] st;
    logic [4:0] we;
  } vec_t;

  typedef struct {
    logic       chk_st;
    logic [3:0] st;
    logic [4:0] we;
    logic [8:0] mux;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Mux-select table per state: {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, Aluop}
  function automatic logic [8:0] mux_of(input logic [3:0] s);
    case (s)
      4'd0:    return 9'b0_10_00_10_00;
      4'd1:    return 9'b0_00_01_01_00;
      4'd2:    return 9'b0_00_10_01_00;
      4'd3:    return 9'b1_00_00_00_00;
      4'd4:    return 9'b0_01_00_00_00;
      4'd5:    return 9'b1_00_00_00_00;
      4'd6:    return 9'b0_00_10_00_10;
      4'd7:    return 9'b0_00_00_00_00;
      4'd8:    return 9'b0_00_10_01_10;
      4'd9:    return 9'b0_00_01_10_00;
      default: return 9'b0_00_10_00_01;
    endcase
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic z, input logic m,
                     input logic c, input logic [3:0] s, input logic [4:0] w);
    vec_t v;
    v.rst_n = r; v.op = o; v.zero = z; v.mr = m; v.chk_st = c; v.st = s; v.we = w;
    vecs.push_back(v);
  endtask

  task automatic check(input int idx);
    exp_t       e;
    logic [4:0] we_act;
    logic [8:0] mux_act;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty vec %0d: got no expected entry, required one", idx);
      return;
    end
    e       = sb.pop_front();
    we_act  = {PCWrite, MemWrite, IRWrite, RegWrite, Illegal};
    mux_act = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, Aluop};
    n_cmp++;
    if (we_act !== e.we) begin
      n_bad++;
      $display("FAIL enables vec %0d: got %05b required %05b", idx, we_act, e.we);
    end
    if (e.chk_st) begin
      n_cmp++;
      if (State !== e.st) begin
        n_bad++;
        $display("FAIL state vec %0d: got %0d required %0d", idx, State, e.st);
      end
      n_cmp++;
      if (mux_act !== e.mux) begin
        n_bad++;
        $display("FAIL muxsel vec %0d: got %09b required %09b", idx, mux_act, e.mux);
      end
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    rst_n = v.rst_n; op = v.op; Zero = v.zero; mem_ready = v.mr;
    e.chk_st = v.chk_st; e.st = v.st; e.we = v.we; e.mux = mux_of(v.st);
    sb.push_back(e);
    @(negedge clk);
    check(idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t hv;
    rst_n = 1'b0; op = 7'd0; Zero = 1'b0; mem_ready = 1'b0;

    // Reset with random inputs; state is unknown until the first edge.
    add(0, 7'($urandom), 1'($urandom), 1'($urandom), 0, 4'd0, W0);
    add(0, 7'($urandom), 1'($urandom), 1'($urandom), 1, 4'd0, W0);
    add(0, 7'($urandom), 1'($urandom), 1'($urandom), 1, 4'd0, W0);
    // FETCH stall then lw with one MEMREAD stall: 0,0,1,2,3,3,4
    add(1, LW, 0, 0, 1, 4'd0, W0);
    add(1, LW, 0, 1, 1, 4'd0, WF);
    add(1, LW, 0, 1, 1, 4'd1, W0);
    add(1, LW, 0, 1, 1, 4'd2, W0);
    add(1, LW, 0, 0, 1, 4'd3, W0);
    add(1, LW, 0, 1, 1, 4'd3, W0);
    add(1, LW, 0, 1, 1, 4'd4, WR);
    // lw unstalled: 0,1,2,3,4
    add(1, LW, 0, 1, 1, 4'd0, WF);
    add(1, LW, 0, 1, 1, 4'd1, W0);
    add(1, LW, 0, 1, 1, 4'd2, W0);
    add(1, LW, 0, 1, 1, 4'd3, W0);
    add(1, LW, 0, 1, 1, 4'd4, WR);
    // sw with two stall cycles in MEMWRITE
    add(1, SW, 0, 1, 1, 4'd0, WF);
    add(1, SW, 0, 1, 1, 4'd1, W0);
    add(1, SW, 0, 1, 1, 4'd2, W0);
    add(1, SW, 0, 0, 1, 4'd5, WM);
    add(1, SW, 0, 0, 1, 4'd5, WM);
    add(1, SW, 0, 1, 1, 4'd5, WM);
    // beq taken, then not taken
    add(1, BQ, 1, 1, 1, 4'd0, WF);
    add(1, BQ, 1, 1, 1, 4'd1, W0);
    add(1, BQ, 1, 1, 1, 4'd10, WP);
    add(1, BQ, 0, 1, 1, 4'd0, WF);
    add(1, BQ, 1, 1, 1, 4'd1, W0);
    add(1, BQ, 0, 1, 1, 4'd10, W0);
    // R-type (Zero high must not leak into PCWrite), I-type, jal
    add(1, RT, 1, 1, 1, 4'd0, WF);
    add(1, RT, 1, 1, 1, 4'd1, W0);
    add(1, RT, 1, 1, 1, 4'd6, W0);
    add(1, RT, 1, 1, 1, 4'd7, WR);
    add(1, IT, 0, 1, 1, 4'd0, WF);
    add(1, IT, 0, 1, 1, 4'd1, W0);
    add(1, IT, 0, 1, 1, 4'd8, W0);
    add(1, IT, 0, 1, 1, 4'd7, WR);
    add(1, JL, 0, 1, 1, 4'd0, WF);
    add(1, JL, 0, 1, 1, 4'd1, W0);
    add(1, JL, 0, 1, 1, 4'd9, WP);
    add(1, JL, 0, 1, 1, 4'd7, WR);
    // illegal opcode: two cycles, Illegal only in DECODE
    add(1, BAD, 0, 1, 1, 4'd0, WF);
    add(1, BAD, 0, 1, 1, 4'd1, WI);

    foreach (vecs[i]) apply(vecs[i], i);

    // Hand sequence: FETCH after illegal, then sw interrupted by reset in MEMWRITE.
    hv.chk_st = 1'b1; hv.zero = 1'b0; hv.op = SW;
    hv.rst_n = 1; hv.mr = 1; hv.st = 4'd0; hv.we = WF; apply(hv, 100);
    hv.st = 4'd1; hv.we = W0; apply(hv, 101);
    hv.st = 4'd2; hv.we = W0; apply(hv, 102);
    hv.mr = 0; hv.st = 4'd5; hv.we = WM; apply(hv, 103);
    hv.rst_n = 0; hv.mr = 1; hv.st = 4'd5; hv.we = W0; apply(hv, 104);
    hv.rst_n = 1; hv.mr = 1; hv.st = 4'd0; hv.we = WF; apply(hv, 105);
    hv.st = 4'd1; hv.we = W0; apply(hv, 106);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
